comparator: RTL and testbench
=============================

Name: comparator

Overview:
- 4-bit code to 7-segment converter: input nibble {w,x,y,z} (w = MSB) selects a digit glyph driven on segment outputs a..g.
- Registered output stage: one clock latency, asynchronous active-low reset.
- Sits between a nibble source (counter or BCD datapath) and a single 7-segment display digit.
- Supports hex glyphs or blanking for codes 10–15, and common-cathode or common-anode polarity.

Parameters:
- HEX_EN, 1, 1 = codes 10–15 show A,b,C,d,E,F; 0 = codes 10–15 blank the digit (all segments off).
- ACTIVE_LOW, 0, 0 = segment on drives 1 (common cathode); 1 = segment on drives 0 (common anode), applied to every output including reset value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- w  input  1  code bit 3 (MSB).
- x  input  1  code bit 2.
- y  input  1  code bit 1.
- z  input  1  code bit 0 (LSB).
- a  output  1  segment a (top).
- b  output  1  segment b (upper right).
- c  output  1  segment c (lower right).
- d  output  1  segment d (bottom).
- e  output  1  segment e (lower left).
- f  output  1  segment f (upper left).
- g  output  1  segment g (middle).

Behaviour:
- Reset: rst_n low asynchronously forces all segments off (a..g = 0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1), held while rst_n low.
- Reset release: first rising clk edge with rst_n high registers the decode of the current {w,x,y,z}.
- Latency: outputs reflect the code sampled at the previous rising clk edge. No combinational path from inputs to outputs.
- Decode table, active-high glyph bits listed as abcdefg:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011
  - 10 A = 1110111, 11 b = 0011111, 12 C = 1001110
  - 13 d = 0111101, 14 E = 1001111, 15 F = 1000111
- HEX_EN=0: codes 10–15 produce 0000000 (blank).
- ACTIVE_LOW=1: registered pattern is the bitwise inverse of the above, including the blank case.
- X/Z on inputs: not required to be handled. Every one of the 16 legal codes is fully decoded, with a default branch of blank so no latches are inferred.
- Input changing every cycle: each cycle's code appears exactly one cycle later, with no skipped or merged values.
- Reset asserted mid-stream: outputs go off immediately, without waiting for a clock edge. Decoding resumes on the first edge after release.

Test Plan:
- Reset: rst_n=0 with {w,x,y,z}=1000 and clock running -> a..g = 0000000 throughout; release -> next edge a..g = 1111111.
- Full sweep, defaults: apply codes 0..15, one per cycle -> one cycle later each output matches the table (e.g. 0 -> 1111110, 2 -> 1101101, 9 -> 1111011, 12 -> 1001110, 15 -> 1000111).
- HEX_EN=0: codes 9, 10, 15 -> 1111011, 0000000, 0000000; code 0 -> 1111110.
- ACTIVE_LOW=1: reset -> 1111111; code 8 -> 0000000; code 1 -> 1001111.
- Latency check: input changes from 3 to 7 just after an edge -> outputs hold 1111001 until the next rising edge, then show 1110000.
- Async reset mid-stream: code 6 displayed (1011111), rst_n pulses low between edges -> outputs go 0000000 before the next edge, then recover to 1011111 after release.

Source files
------------

// File: rtl/comparator.sv
// -----------------------------------------------------------------------------
// comparator
//
// Purpose:
//   Converts a 4-bit code {w,x,y,z} (w = MSB) into a 7-segment glyph and
//   registers it. The output stage adds one clock of latency. There is no
//   combinational path from the code inputs to the segment outputs.
//   Codes 10-15 show the hex glyphs A,b,C,d,E,F when HEX_EN = 1. When
//   HEX_EN = 0 they blank the digit. ACTIVE_LOW selects the drive polarity
//   for a common-cathode (0) or a common-anode (1) display.
//
// Parameters:
//   HEX_EN      1: codes 10-15 show hex glyphs; 0: codes 10-15 blank.
//   ACTIVE_LOW  0: a lit segment drives 1; 1: a lit segment drives 0.
//               The polarity also applies to the reset value.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset (all segments off)
//   w,x,y,z     code bits 3..0
//   a..g        segment outputs (a top, b upper right, c lower right,
//               d bottom, e lower left, f upper left, g middle)
// -----------------------------------------------------------------------------
module comparator #(
  parameter bit HEX_EN     = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic w,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  // Pattern for "all segments off" at the selected polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

  logic [3:0] code;
  logic [6:0] glyph;     // active-high glyph, bit order abcdefg (a = bit 6)
  logic [6:0] seg_next;  // glyph at the output polarity
  logic [6:0] seg_q;

  assign code = {w, x, y, z};

  always_comb begin
    glyph = 7'b000_0000;
    case (code)
      4'd0:  glyph = 7'b111_1110;
      4'd1:  glyph = 7'b011_0000;
      4'd2:  glyph = 7'b110_1101;
      4'd3:  glyph = 7'b111_1001;
      4'd4:  glyph = 7'b011_0011;
      4'd5:  glyph = 7'b101_1011;
      4'd6:  glyph = 7'b101_1111;
      4'd7:  glyph = 7'b111_0000;
      4'd8:  glyph = 7'b111_1111;
      4'd9:  glyph = 7'b111_1011;
      4'd10: glyph = HEX_EN ? 7'b111_0111 : 7'b000_0000;  // A
      4'd11: glyph = HEX_EN ? 7'b001_1111 : 7'b000_0000;  // b
      4'd12: glyph = HEX_EN ? 7'b100_1110 : 7'b000_0000;  // C
      4'd13: glyph = HEX_EN ? 7'b011_1101 : 7'b000_0000;  // d
      4'd14: glyph = HEX_EN ? 7'b100_1111 : 7'b000_0000;  // E
      4'd15: glyph = HEX_EN ? 7'b100_0111 : 7'b000_0000;  // F
      default: glyph = 7'b000_0000;
    endcase
  end

  // The output polarity is applied before the register. This way the
  // registered value and the reset value use the same convention.
  assign seg_next = ACTIVE_LOW ? ~glyph : glyph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_next;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_comparator.sv
// -----------------------------------------------------------------------------
// tb_comparator
//
// Three instances share one stimulus:
//   dut_def : defaults (HEX_EN=1, ACTIVE_LOW=0)
//   dut_nhx : HEX_EN=0
//   dut_low : ACTIVE_LOW=1
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// or #1 after a rising edge where the latency matters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_comparator;

  logic       clk;
  logic       rst_n;
  logic [3:0] code;
  logic [6:0] seg_def, seg_nhx, seg_low;

  int passed = 0;
  int total  = 0;

  logic [6:0] glyph_tab [16];
  logic [6:0] exp_q[$];

  comparator #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) dut_def (
    .clk(clk), .rst_n(rst_n),
    .w(code[3]), .x(code[2]), .y(code[1]), .z(code[0]),
    .a(seg_def[6]), .b(seg_def[5]), .c(seg_def[4]), .d(seg_def[3]),
    .e(seg_def[2]), .f(seg_def[1]), .g(seg_def[0])
  );

  comparator #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) dut_nhx (
    .clk(clk), .rst_n(rst_n),
    .w(code[3]), .x(code[2]), .y(code[1]), .z(code[0]),
    .a(seg_nhx[6]), .b(seg_nhx[5]), .c(seg_nhx[4]), .d(seg_nhx[3]),
    .e(seg_nhx[2]), .f(seg_nhx[1]), .g(seg_nhx[0])
  );

  comparator #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b1)) dut_low (
    .clk(clk), .rst_n(rst_n),
    .w(code[3]), .x(code[2]), .y(code[1]), .z(code[0]),
    .a(seg_low[6]), .b(seg_low[5]), .c(seg_low[4]), .d(seg_low[3]),
    .e(seg_low[2]), .f(seg_low[1]), .g(seg_low[0])
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n = 1'b0;
    code  = 4'd0;
  end

  // driver task: apply a code on the falling edge
  task automatic drive_code(input logic [3:0] v);
    @(negedge clk);
    code = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    code  = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (seg_def !== 7'b000_0000)
        $display("FAIL reset_def cyc%0d got %b exp 0000000", i, seg_def);
      else passed++;
      total++;
      if (seg_low !== 7'b111_1111)
        $display("FAIL reset_low cyc%0d got %b exp 1111111", i, seg_low);
      else passed++;
    end
    rst_n = 1'b1;  // released at a falling edge
    @(posedge clk); #1;
    total++;
    if (seg_def !== 7'b111_1111)
      $display("FAIL reset_release_def got %b exp 1111111", seg_def);
    else passed++;
    total++;
    if (seg_low !== 7'b000_0000)
      $display("FAIL reset_release_low got %b exp 0000000", seg_low);
    else passed++;
  endtask

  // Back-to-back sweep 0..15, one code per cycle, checked through exp_q.
  task automatic test_sweep();
    logic [6:0] exp;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = exp_q.pop_front();
        total++;
        if (seg_def !== exp)
          $display("FAIL sweep code%0d got %b exp %b", i - 1, seg_def, exp);
        else passed++;
      end
      if (i < 16) begin
        code = 4'(i);
        exp_q.push_back(glyph_tab[i]);
      end
    end
  endtask

  task automatic test_hex_off();
    logic [3:0] codes [4];
    logic [6:0] exps  [4];
    codes[0] = 4'd9;  exps[0] = 7'b111_1011;
    codes[1] = 4'd10; exps[1] = 7'b000_0000;
    codes[2] = 4'd15; exps[2] = 7'b000_0000;
    codes[3] = 4'd0;  exps[3] = 7'b111_1110;
    for (int i = 0; i < 4; i++) begin
      drive_code(codes[i]);
      @(negedge clk);
      total++;
      if (seg_nhx !== exps[i])
        $display("FAIL hex_off code%0d got %b exp %b", codes[i], seg_nhx, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_active_low();
    drive_code(4'd8);
    @(negedge clk);
    total++;
    if (seg_low !== 7'b000_0000)
      $display("FAIL active_low code8 got %b exp 0000000", seg_low);
    else passed++;
    drive_code(4'd1);
    @(negedge clk);
    total++;
    if (seg_low !== 7'b100_1111)
      $display("FAIL active_low code1 got %b exp 1001111", seg_low);
    else passed++;
    drive_code(4'd10);
    @(negedge clk);
    total++;
    if (seg_low !== 7'b000_1000)
      $display("FAIL active_low codeA got %b exp 0001000", seg_low);
    else passed++;
  endtask

  task automatic test_latency();
    drive_code(4'd3);
    @(posedge clk); #1;
    code = 4'd7;  // changes just after the edge
    #1;
    total++;
    if (seg_def !== 7'b111_1001)
      $display("FAIL latency_hold_early got %b exp 1111001", seg_def);
    else passed++;
    @(negedge clk);
    total++;
    if (seg_def !== 7'b111_1001)
      $display("FAIL latency_hold_mid got %b exp 1111001", seg_def);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (seg_def !== 7'b111_0000)
      $display("FAIL latency_update got %b exp 1110000", seg_def);
    else passed++;
  endtask

  task automatic test_async_reset();
    drive_code(4'd6);
    @(negedge clk);
    total++;
    if (seg_def !== 7'b101_1111)
      $display("FAIL async_pre got %b exp 1011111", seg_def);
    else passed++;
    #1 rst_n = 1'b0;  // between edges
    #1;
    total++;
    if (seg_def !== 7'b000_0000)
      $display("FAIL async_assert_def got %b exp 0000000", seg_def);
    else passed++;
    total++;
    if (seg_low !== 7'b111_1111)
      $display("FAIL async_assert_low got %b exp 1111111", seg_low);
    else passed++;
    #1 rst_n = 1'b1;  // released before the next rising edge
    #1;
    total++;
    if (seg_def !== 7'b000_0000)
      $display("FAIL async_released_hold got %b exp 0000000", seg_def);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (seg_def !== 7'b101_1111)
      $display("FAIL async_recover got %b exp 1011111", seg_def);
    else passed++;
  endtask

  initial begin
    glyph_tab[0]  = 7'b111_1110; glyph_tab[1]  = 7'b011_0000;
    glyph_tab[2]  = 7'b110_1101; glyph_tab[3]  = 7'b111_1001;
    glyph_tab[4]  = 7'b011_0011; glyph_tab[5]  = 7'b101_1011;
    glyph_tab[6]  = 7'b101_1111; glyph_tab[7]  = 7'b111_0000;
    glyph_tab[8]  = 7'b111_1111; glyph_tab[9]  = 7'b111_1011;
    glyph_tab[10] = 7'b111_0111; glyph_tab[11] = 7'b001_1111;
    glyph_tab[12] = 7'b100_1110; glyph_tab[13] = 7'b011_1101;
    glyph_tab[14] = 7'b100_1111; glyph_tab[15] = 7'b100_0111;

    test_reset();
    test_sweep();
    test_hex_off();
    test_active_low();
    test_latency();
    test_async_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
